multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle successor to the single-cycle instruction decoder: an FSM sequencing FETCH/DECODE/EXEC/MEM/WB
//  for the same ISA (add, sub, jr, ori, lw, sw, beq, lui, jal, lb, sb). Sits between the IR/datapath and a
//  shared instruction+data memory with a req/ack handshake. Adds bus timeout detection and a retired-instruction counter.
// PARAMETERS
//  ALUCTRL_W    3   width of alu_ctrl (codes: 0=OR, 1=LUI, 2=ADD, 3=SUB)
//  NPC_OP_W     3   width of npc_op (0=PC+4, 1=BEQ target, 2=JAL target, 3=JR rs)
//  TIMEOUT_CYC  16  max cycles mem_req may wait for mem_ack before bus_err (>=2)
//  CNT_W        32  width of retired-instruction counter
//  EN_BYTE      1   1: lb/sb legal; 0: lb/sb decode as illegal
// PORTS
//  clk          in   1          clock, all state on rising edge
//  reset        in   1          synchronous, active-high
//  instr        in   32         IR contents (valid from DECODE onward)
//  alu_zero     in   1          ALU zero flag, sampled in EXEC for beq
//  mem_ack      in   1          memory completes current request this cycle
//  mem_req      out  1          memory request (held until ack or timeout)
//  mem_we       out  1          request is a write (sw/sb)
//  iord         out  1          0=address from PC, 1=address from ALUOut
//  ir_we        out  1          load IR from memory read data
//  pc_we        out  1          update PC using npc_op
//  npc_op       out  NPC_OP_W   next-PC select
//  reg_we       out  1          register-file write enable
//  reg_dst      out  1          1=rd, 0=rt
//  mem_to_reg   out  1          write-back from MDR
//  jal_sel      out  1          write PC+4 to $31
//  ext_op       out  1          1=sign-extend imm16, 0=zero-extend
//  alu_src      out  1          1=immediate, 0=rt
//  alu_ctrl     out  ALUCTRL_W  ALU operation
//  lb_sel       out  1          byte load
//  sb_sel       out  1          byte store
//  illegal      out  1          1-cycle pulse: unsupported opcode/funct
//  bus_err      out  1          1-cycle pulse: memory timeout
//  retired      out  CNT_W      count of completed legal instructions
// BEHAVIOUR
//  - Reset: state=FETCH, timeout counter=0, retired=0; every output 0 during the reset cycle and the cycle after.
//  - Outputs are Moore: decoded from registered state + opcode/funct latched on DECODE entry.
//  - FETCH: mem_req=1, iord=0. On mem_ack: ir_we=1, pc_we=1, npc_op=0 -> DECODE.
//  - DECODE: latch opcode/funct; classify. Illegal -> illegal pulse, -> FETCH (no writes). jal: reg_we, jal_sel,
//    pc_we npc_op=2 -> FETCH. Otherwise -> EXEC.
//  - EXEC: alu_ctrl/ext_op/alu_src per instruction. beq: pc_we=alu_zero, npc_op=1 -> FETCH. jr: pc_we, npc_op=3
//    -> FETCH. lw/lb/sw/sb -> MEM. R-type/ori/lui -> WB.
//  - MEM: mem_req=1, iord=1, mem_we=sw|sb, sb_sel/lb_sel. On ack: stores -> FETCH; loads -> WB.
//  - WB: reg_we=1; reg_dst=1 for R-type; mem_to_reg=1 for loads (lb_sel held) -> FETCH.
//  - Cycle counts with zero-wait ack: R/ori/lui 4, lw/lb 5, sw/sb 4, beq/jr 3, jal 2.
//  - Handshake: mem_req, iord, mem_we stable until ack. mem_ack with mem_req=0 ignored. Ack in the first req cycle is legal.
//  - Timeout: counter increments each cycle mem_req=1 and no ack. At TIMEOUT_CYC: bus_err pulse,
//    counter clears, -> FETCH. Instruction is not retired; PC is not written.
//  - retired increments once on the final cycle of every legal instruction (incl. beq not taken). Wraps modulo 2^CNT_W.
//  - reset asserted in any state aborts: no reg_we/pc_we/mem_req the next cycle.
// STRUCTURE
//  - Shared package: opcode/funct localparams, ALU and NPC op codes, state encoding (3-bit enum).
//  - Sub-module ctrl_insn_class: combinational opcode/funct -> class {RTYPE,IMM,LOAD,STORE,BR,JR,JAL,ILL}
//    + alu_ctrl/ext_op/byte flags. FSM, timeout counter and retired counter stay in this module.
// TESTING
//  - add $3,$1,$2 with ack immediate -> reg_we=1, reg_dst=1 in cycle 4; retired 0->1.
//  - lw with ack delayed 3 cycles in MEM -> mem_req held 4 cycles, iord=1; WB mem_to_reg=1; total 8 cycles.
//  - beq, alu_zero=1 vs 0 -> pc_we=1/npc_op=1 vs pc_we=0 in EXEC; both 3 cycles, retired +1.
//  - No ack for TIMEOUT_CYC=16 in FETCH -> bus_err pulse on cycle 16, back to FETCH, retired unchanged.
//  - Opcode 6'b111111 -> illegal pulse in DECODE, no writes; EN_BYTE=0 with sb -> illegal.
//  - reset asserted mid-MEM of sw -> mem_req=0 next cycle, state FETCH, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle controller: ISA opcodes/functs, ALU and
// next-PC op codes, FSM state encoding and the instruction class type.
package multicycle_ctrl_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_OR   = 3'd0;
    localparam logic [2:0] ALU_LUI  = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SUB  = 3'd3;

    localparam logic [2:0] NPC_SEQ  = 3'd0;
    localparam logic [2:0] NPC_BEQ  = 3'd1;
    localparam logic [2:0] NPC_JAL  = 3'd2;
    localparam logic [2:0] NPC_JR   = 3'd3;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BR,
        CLS_JR,
        CLS_JAL,
        CLS_ILL
    } insn_class_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Request/acknowledge port to the shared instruction+data memory.
interface multicycle_ctrl_fsm_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output iord, input mem_ack);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl_fsm_ctrl_insn_class.sv
// Combinational opcode/funct classifier: instruction class, ALU operation,
// immediate extension, ALU operand select and byte-access flag.
module ctrl_insn_class
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter bit EN_BYTE   = 1'b1
) (
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    output insn_class_t          cls,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic                 ext_op,
    output logic                 alu_src,
    output logic                 is_byte
);

    logic [2:0] alu_code;

    always_comb begin
        cls      = CLS_ILL;
        alu_code = ALU_OR;
        ext_op   = 1'b0;
        alu_src  = 1'b0;
        is_byte  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin cls = CLS_RTYPE; alu_code = ALU_ADD; end
                    FN_SUB:  begin cls = CLS_RTYPE; alu_code = ALU_SUB; end
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_ILL;
                endcase
            end
            OP_ORI: begin cls = CLS_IMM; alu_code = ALU_OR;  alu_src = 1'b1; end
            OP_LUI: begin cls = CLS_IMM; alu_code = ALU_LUI; alu_src = 1'b1; end
            OP_LW: begin
                cls = CLS_LOAD; alu_code = ALU_ADD; ext_op = 1'b1; alu_src = 1'b1;
            end
            OP_SW: begin
                cls = CLS_STORE; alu_code = ALU_ADD; ext_op = 1'b1; alu_src = 1'b1;
            end
            // Byte accesses fall through to illegal when the byte lane is not built.
            OP_LB: begin
                if (EN_BYTE) begin
                    cls = CLS_LOAD; alu_code = ALU_ADD; ext_op = 1'b1; alu_src = 1'b1;
                    is_byte = 1'b1;
                end
            end
            OP_SB: begin
                if (EN_BYTE) begin
                    cls = CLS_STORE; alu_code = ALU_ADD; ext_op = 1'b1; alu_src = 1'b1;
                    is_byte = 1'b1;
                end
            end
            OP_BEQ: begin cls = CLS_BR; alu_code = ALU_SUB; ext_op = 1'b1; end
            OP_JAL: cls = CLS_JAL;
            default: cls = CLS_ILL;
        endcase
    end

    assign alu_ctrl = ALUCTRL_W'(alu_code);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with memory timeout and a
// retired-instruction counter.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  ST_FETCH  | instruction read from PC; on ack load IR and PC+4
//  ST_DECODE | classify IR; illegal and jal finish here
//  ST_EXEC   | ALU operation; beq and jr finish here
//  ST_MEM    | data access at ALUOut; stores finish on ack
//  ST_WB     | register write-back from ALU or MDR
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int ALUCTRL_W   = 3,
    parameter int NPC_OP_W    = 3,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32,
    parameter bit EN_BYTE     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr,
    input  logic                  alu_zero,
    multicycle_ctrl_fsm_if.master bus,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic [NPC_OP_W-1:0]   npc_op,
    output logic                  reg_we,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  jal_sel,
    output logic                  ext_op,
    output logic                  alu_src,
    output logic [ALUCTRL_W-1:0]  alu_ctrl,
    output logic                  lb_sel,
    output logic                  sb_sel,
    output logic                  illegal,
    output logic                  bus_err,
    output logic [CNT_W-1:0]      retired
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic                 boot;
    logic                 quiet;
    logic [TW-1:0]        tmo_cnt;
    logic [CNT_W-1:0]     retired_q;
    logic [5:0]           op_q;
    logic [5:0]           fn_q;
    logic [5:0]           op_sel;
    logic [5:0]           fn_sel;
    insn_class_t          cls;
    logic [ALUCTRL_W-1:0] cls_alu;
    logic                 cls_ext;
    logic                 cls_src;
    logic                 cls_byte;
    logic                 req_active;
    logic                 ack_ok;
    logic                 tmo_hit;
    logic                 retire;
    logic                 mem_req_c;
    logic                 mem_we_c;
    logic                 iord_c;
    logic [2:0]           npc_code;
    logic                 unused_instr_bits;

    // Outputs are held low while reset is applied and for one cycle after it.
    assign quiet = reset | boot;

    // DECODE classifies straight from the IR; later states use the copy latched there.
    assign op_sel = (state == ST_DECODE) ? instr[31:26] : op_q;
    assign fn_sel = (state == ST_DECODE) ? instr[5:0]   : fn_q;
    assign unused_instr_bits = ^instr[25:6];

    ctrl_insn_class #(
        .ALUCTRL_W (ALUCTRL_W),
        .EN_BYTE   (EN_BYTE)
    ) u_class (
        .opcode   (op_sel),
        .funct    (fn_sel),
        .cls      (cls),
        .alu_ctrl (cls_alu),
        .ext_op   (cls_ext),
        .alu_src  (cls_src),
        .is_byte  (cls_byte)
    );

    assign req_active = !quiet && (state == ST_FETCH || state == ST_MEM);
    assign ack_ok     = req_active && bus.mem_ack;
    assign tmo_hit    = req_active && !bus.mem_ack && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        if (!quiet) begin
            case (state)
                ST_FETCH: begin
                    if (ack_ok) state_nxt = ST_DECODE;
                    else if (tmo_hit) state_nxt = ST_FETCH;
                end
                ST_DECODE: begin
                    case (cls)
                        CLS_ILL: state_nxt = ST_FETCH;
                        CLS_JAL: begin state_nxt = ST_FETCH; retire = 1'b1; end
                        default: state_nxt = ST_EXEC;
                    endcase
                end
                ST_EXEC: begin
                    case (cls)
                        CLS_BR, CLS_JR:     begin state_nxt = ST_FETCH; retire = 1'b1; end
                        CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
                        default:             state_nxt = ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (ack_ok) begin
                        if (cls == CLS_STORE) begin
                            state_nxt = ST_FETCH;
                            retire    = 1'b1;
                        end else begin
                            state_nxt = ST_WB;
                        end
                    end else if (tmo_hit) begin
                        state_nxt = ST_FETCH;
                    end
                end
                ST_WB: begin
                    state_nxt = ST_FETCH;
                    retire    = 1'b1;
                end
                default: state_nxt = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_FETCH;
            boot      <= 1'b1;
            tmo_cnt   <= '0;
            retired_q <= '0;
            op_q      <= '0;
            fn_q      <= '0;
        end else begin
            boot  <= 1'b0;
            state <= state_nxt;
            if (req_active && !bus.mem_ack && !tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
            else tmo_cnt <= '0;
            if (retire) retired_q <= retired_q + CNT_W'(1);
            if (!quiet && state == ST_DECODE) begin
                op_q <= instr[31:26];
                fn_q <= instr[5:0];
            end
        end
    end

    always_comb begin
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        iord_c     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        npc_code   = NPC_SEQ;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        jal_sel    = 1'b0;
        ext_op     = 1'b0;
        alu_src    = 1'b0;
        alu_ctrl   = '0;
        lb_sel     = 1'b0;
        sb_sel     = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        if (!quiet) begin
            case (state)
                ST_FETCH: begin
                    mem_req_c = 1'b1;
                    ir_we     = bus.mem_ack;
                    pc_we     = bus.mem_ack;
                    bus_err   = tmo_hit;
                end
                ST_DECODE: begin
                    if (cls == CLS_ILL) illegal = 1'b1;
                    if (cls == CLS_JAL) begin
                        reg_we   = 1'b1;
                        jal_sel  = 1'b1;
                        pc_we    = 1'b1;
                        npc_code = NPC_JAL;
                    end
                end
                ST_EXEC: begin
                    alu_ctrl = cls_alu;
                    ext_op   = cls_ext;
                    alu_src  = cls_src;
                    if (cls == CLS_BR) begin
                        pc_we    = alu_zero;
                        npc_code = NPC_BEQ;
                    end
                    if (cls == CLS_JR) begin
                        pc_we    = 1'b1;
                        npc_code = NPC_JR;
                    end
                end
                ST_MEM: begin
                    mem_req_c = 1'b1;
                    iord_c    = 1'b1;
                    mem_we_c  = (cls == CLS_STORE);
                    sb_sel    = (cls == CLS_STORE) && cls_byte;
                    lb_sel    = (cls == CLS_LOAD) && cls_byte;
                    bus_err   = tmo_hit;
                end
                ST_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = (cls == CLS_RTYPE);
                    mem_to_reg = (cls == CLS_LOAD);
                    lb_sel     = (cls == CLS_LOAD) && cls_byte;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req = mem_req_c;
    assign bus.mem_we  = mem_we_c;
    assign bus.iord    = iord_c;
    assign npc_op      = NPC_OP_W'(npc_code);
    assign retired     = quiet ? '0 : retired_q;

endmodule
